line_buf_pingpong: RTL and testbench



---
 rtl/line_buf_pingpong.sv | 224 ++++++++++++++++++++++
 tb/tb_line_buf_pingpong.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_pingpong.sv
// Ping-pong scanline buffer controller: the renderer fills the back bank of
// single-port SRAM macros while scanout reads the front bank; banks swap on line start.
module line_buf_pingpong #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int LINE_LEN = 256
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [CHANNELS*DATA_W-1:0]   wr_data,
    input  logic                         rd_start,
    output logic                         rd_valid,
    output logic [CHANNELS*DATA_W-1:0]   rd_data,
    output logic                         rd_busy,
    output logic                         swap_o,
    output logic                         underrun_o,
    output logic                         start_err_o,
    output logic                         front_sel,
    output logic [ADDR_W-1:0]            bank_a_a,
    output logic [ADDR_W-1:0]            bank_b_a,
    output logic [CHANNELS*DATA_W-1:0]   bank_a_d,
    output logic [CHANNELS*DATA_W-1:0]   bank_b_d,
    input  logic [CHANNELS*DATA_W-1:0]   bank_a_q,
    input  logic [CHANNELS*DATA_W-1:0]   bank_b_q,
    output logic                         bank_a_cen,
    output logic                         bank_b_cen,
    output logic                         bank_a_gwen,
    output logic                         bank_b_gwen,
    output logic [CHANNELS*DATA_W-1:0]   bank_a_wen,
    output logic [CHANNELS*DATA_W-1:0]   bank_b_wen
);

    localparam int PIX_W = CHANNELS * DATA_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic              cen;
        logic              gwen;
        logic [PIX_W-1:0]  wen;
        logic [ADDR_W-1:0] a;
        logic [PIX_W-1:0]  d;
    } macro_t;

    rd_state_e        state_q, state_d;
    logic             front_sel_q, front_sel_d;
    logic             back_full_q, back_full_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_valid_q;
    logic             rd_sel_q;

    logic   wr_fire_s, rd_issue_s, start_s;
    logic   swap_s, underrun_s, start_err_s;
    logic   a_wr_s, b_wr_s, a_rd_s, b_rd_s;
    macro_t bank_a_s, bank_b_s;

    // Single-port macro drive: a write, a read, or the quiet idle pattern.
    function automatic macro_t macro_drive(input logic              wr,
                                           input logic              rd,
                                           input logic [ADDR_W-1:0] wa,
                                           input logic [ADDR_W-1:0] ra,
                                           input logic [PIX_W-1:0]  wd);
        macro_t m;
        if (wr) begin
            m.cen  = 1'b0;
            m.gwen = 1'b0;
            m.wen  = '0;
            m.a    = wa;
            m.d    = wd;
        end else if (rd) begin
            m.cen  = 1'b0;
            m.gwen = 1'b1;
            m.wen  = '1;
            m.a    = ra;
            m.d    = '0;
        end else begin
            m.cen  = 1'b1;
            m.gwen = 1'b1;
            m.wen  = '1;
            m.a    = '0;
            m.d    = '0;
        end
        return m;
    endfunction

    // Reset gates every access so nothing reaches a macro while it is asserted.
    assign wr_fire_s  = wr_valid & ~back_full_q & ~wb_rst_i;
    assign rd_issue_s = (state_q == ST_READ) & ~wb_rst_i;
    assign start_s    = rd_start & ~wb_rst_i;

    // Reader FSM next state, swap decision and event pulses.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        front_sel_d = front_sel_q;
        swap_s      = 1'b0;
        underrun_s  = 1'b0;
        start_err_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d  = ST_READ;
                    rd_cnt_d = '0;
                    if (back_full_q) begin
                        front_sel_d = ~front_sel_q;
                        swap_s      = 1'b1;
                    end else begin
                        underrun_s  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                start_err_s = start_s;
                if (rd_cnt_q == LAST) begin
                    state_d  = ST_DRAIN;
                    rd_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                start_err_s = start_s;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write pointer and back-bank full flag; a write and a swap never share a cycle.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        back_full_d = back_full_q;
        if (wr_fire_s) begin
            if (wr_cnt_q == LAST) begin
                wr_cnt_d    = '0;
                back_full_d = 1'b1;
            end else begin
                wr_cnt_d    = wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (swap_s) begin
            back_full_d = 1'b0;
        end else begin
            back_full_d = back_full_q;
        end
    end

    // Back bank is the one not selected as front; reads go to the front bank.
    assign a_wr_s = wr_fire_s  &  front_sel_q;
    assign b_wr_s = wr_fire_s  & ~front_sel_q;
    assign a_rd_s = rd_issue_s & ~front_sel_q;
    assign b_rd_s = rd_issue_s &  front_sel_q;

    // Per-bank macro control.
    always_comb begin
        bank_a_s = macro_drive(a_wr_s, a_rd_s, wr_cnt_q[ADDR_W-1:0],
                               rd_cnt_q[ADDR_W-1:0], wr_data);
        bank_b_s = macro_drive(b_wr_s, b_rd_s, wr_cnt_q[ADDR_W-1:0],
                               rd_cnt_q[ADDR_W-1:0], wr_data);
    end

    assign bank_a_cen  = bank_a_s.cen;
    assign bank_a_gwen = bank_a_s.gwen;
    assign bank_a_wen  = bank_a_s.wen;
    assign bank_a_a    = bank_a_s.a;
    assign bank_a_d    = bank_a_s.d;
    assign bank_b_cen  = bank_b_s.cen;
    assign bank_b_gwen = bank_b_s.gwen;
    assign bank_b_wen  = bank_b_s.wen;
    assign bank_b_a    = bank_b_s.a;
    assign bank_b_d    = bank_b_s.d;

    // State registers with synchronous reset; SRAM contents are left alone.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
            back_full_q <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            back_full_q <= back_full_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_valid_q  <= (state_q == ST_READ);
            rd_sel_q    <= front_sel_q;
        end
    end

    // Macro q arrives one cycle after the address; pick the bank that was read.
    always_comb begin
        if (rd_valid_q) begin
            rd_data = rd_sel_q ? bank_b_q : bank_a_q;
        end else begin
            rd_data = '0;
        end
    end

    assign wr_ready    = ~back_full_q;
    assign rd_valid    = rd_valid_q;
    assign rd_busy     = (state_q != ST_IDLE);
    assign front_sel   = front_sel_q;
    assign swap_o      = swap_s;
    assign underrun_o  = underrun_s;
    assign start_err_o = start_err_s;

endmodule

// File: tb/tb_line_buf_pingpong.sv
// Self-checking bench for line_buf_pingpong with behavioural SRAM macros and a
// line-level reference model of the ping-pong buffer.
module tb_line_buf_pingpong;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int L  = 16;
    localparam int PW = CH * DW;
    localparam int BW = 2 + PW + AW + PW;

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          wr_valid = 1'b0;
    logic [PW-1:0] wr_data = '0;
    logic          rd_start = 1'b0;
    logic          wr_ready, rd_valid, rd_busy, swap_o, underrun_o, start_err_o, front_sel;
    logic [PW-1:0] rd_data;
    logic [AW-1:0] bank_a_a, bank_b_a;
    logic [PW-1:0] bank_a_d, bank_b_d, bank_a_wen, bank_b_wen;
    logic [PW-1:0] bank_a_q = '0;
    logic [PW-1:0] bank_b_q = '0;
    logic          bank_a_cen, bank_b_cen, bank_a_gwen, bank_b_gwen;

    logic [PW-1:0] mem_a [0:(1<<AW)-1] = '{default: '0};
    logic [PW-1:0] mem_b [0:(1<<AW)-1] = '{default: '0};

    // reference model: line contents per bank plus buffer/reader status
    logic [PW-1:0] md_a [0:L-1] = '{default: '0};
    logic [PW-1:0] md_b [0:L-1] = '{default: '0};
    int m_front = 0;
    int m_full  = 0;
    int m_wcnt  = 0;
    int m_rphase = 0;   // 0 idle; cycles elapsed since the accepted line start

    int errors = 0;
    int checks = 0;

    logic          obs_ready, obs_swap, obs_under, obs_serr, obs_valid, obs_front, obs_busy;
    logic [PW-1:0] obs_data;

    always #5 clk = ~clk;

    line_buf_pingpong #(.CHANNELS(CH), .DATA_W(DW), .ADDR_W(AW), .LINE_LEN(L)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_start(rd_start), .rd_valid(rd_valid), .rd_data(rd_data), .rd_busy(rd_busy),
        .swap_o(swap_o), .underrun_o(underrun_o), .start_err_o(start_err_o),
        .front_sel(front_sel),
        .bank_a_a(bank_a_a), .bank_b_a(bank_b_a),
        .bank_a_d(bank_a_d), .bank_b_d(bank_b_d),
        .bank_a_q(bank_a_q), .bank_b_q(bank_b_q),
        .bank_a_cen(bank_a_cen), .bank_b_cen(bank_b_cen),
        .bank_a_gwen(bank_a_gwen), .bank_b_gwen(bank_b_gwen),
        .bank_a_wen(bank_a_wen), .bank_b_wen(bank_b_wen)
    );

    // single-port SRAM macro A: active-low controls, 1-cycle read latency
    always @(posedge clk) begin
        if (!bank_a_cen) begin
            if (!bank_a_gwen) mem_a[bank_a_a] <= (mem_a[bank_a_a] & bank_a_wen) | (bank_a_d & ~bank_a_wen);
            else              bank_a_q <= mem_a[bank_a_a];
        end
    end

    // single-port SRAM macro B
    always @(posedge clk) begin
        if (!bank_b_cen) begin
            if (!bank_b_gwen) mem_b[bank_b_a] <= (mem_b[bank_b_a] & bank_b_wen) | (bank_b_d & ~bank_b_wen);
            else              bank_b_q <= mem_b[bank_b_a];
        end
    end

    // one clock cycle: drive inputs, check every output against the model, advance the model
    task automatic step(input logic rst, input logic wv, input logic [PW-1:0] wd, input logic rs);
        logic          wfire, rd_now, old_full;
        logic [PW-1:0] exp_px;
        logic [BW-1:0] idle_v, exp_a, exp_b, got_a, got_b;
        @(negedge clk);
        wb_rst_i = rst; wr_valid = wv; wr_data = wd; rd_start = rs;
        #1;
        obs_ready = wr_ready; obs_swap = swap_o; obs_under = underrun_o; obs_serr = start_err_o;
        obs_valid = rd_valid; obs_data = rd_data; obs_front = front_sel; obs_busy = rd_busy;
        wfire  = wv && (m_full == 0);
        rd_now = (m_rphase >= 1) && (m_rphase <= L);
        if (!rst) begin
            checks++;
            if (wr_ready !== (m_full == 0)) begin errors++; $display("FAIL wr_ready t=%0t got=%b exp=%b", $time, wr_ready, m_full == 0); end
            checks++;
            if (front_sel !== (m_front != 0)) begin errors++; $display("FAIL front_sel t=%0t got=%b exp=%0d", $time, front_sel, m_front); end
            checks++;
            if (rd_busy !== (m_rphase != 0)) begin errors++; $display("FAIL rd_busy t=%0t got=%b exp=%b", $time, rd_busy, m_rphase != 0); end
            checks++;
            if (rd_valid !== (m_rphase >= 2)) begin errors++; $display("FAIL rd_valid t=%0t got=%b exp=%b", $time, rd_valid, m_rphase >= 2); end
            if (m_rphase >= 2) begin
                exp_px = (m_front != 0) ? md_b[m_rphase-2] : md_a[m_rphase-2];
                checks++;
                if (rd_data !== exp_px) begin errors++; $display("FAIL rd_data t=%0t got=%h exp=%h", $time, rd_data, exp_px); end
            end
            checks++;
            if (swap_o !== (m_rphase == 0 && rs && m_full != 0)) begin errors++; $display("FAIL swap_o t=%0t got=%b", $time, swap_o); end
            checks++;
            if (underrun_o !== (m_rphase == 0 && rs && m_full == 0)) begin errors++; $display("FAIL underrun_o t=%0t got=%b", $time, underrun_o); end
            checks++;
            if (start_err_o !== (m_rphase != 0 && rs)) begin errors++; $display("FAIL start_err_o t=%0t got=%b", $time, start_err_o); end
            idle_v = {1'b1, 1'b1, {PW{1'b1}}, {AW{1'b0}}, {PW{1'b0}}};
            exp_a = idle_v;
            exp_b = idle_v;
            if (wfire && m_front != 0) exp_a = {1'b0, 1'b0, {PW{1'b0}}, AW'(m_wcnt), wd};
            if (wfire && m_front == 0) exp_b = {1'b0, 1'b0, {PW{1'b0}}, AW'(m_wcnt), wd};
            if (rd_now && m_front == 0) exp_a = {1'b0, 1'b1, {PW{1'b1}}, AW'(m_rphase-1), {PW{1'b0}}};
            if (rd_now && m_front != 0) exp_b = {1'b0, 1'b1, {PW{1'b1}}, AW'(m_rphase-1), {PW{1'b0}}};
            got_a = {bank_a_cen, bank_a_gwen, bank_a_wen, bank_a_a, bank_a_d};
            got_b = {bank_b_cen, bank_b_gwen, bank_b_wen, bank_b_a, bank_b_d};
            checks++;
            if (got_a !== exp_a) begin errors++; $display("FAIL bank_a_drive t=%0t got=%h exp=%h", $time, got_a, exp_a); end
            checks++;
            if (got_b !== exp_b) begin errors++; $display("FAIL bank_b_drive t=%0t got=%h exp=%h", $time, got_b, exp_b); end
        end
        if (rst) begin
            m_front = 0; m_full = 0; m_wcnt = 0; m_rphase = 0;
        end else begin
            old_full = (m_full != 0);
            if (wfire) begin
                if (m_front != 0) md_a[m_wcnt] = wd;
                else              md_b[m_wcnt] = wd;
                m_wcnt++;
                if (m_wcnt == L) begin m_wcnt = 0; m_full = 1; end
            end
            if (m_rphase == 0) begin
                if (rs) begin
                    if (old_full) begin m_front = 1 - m_front; m_full = 0; end
                    m_rphase = 1;
                end
            end else if (m_rphase == L + 1) begin
                m_rphase = 0;
            end else begin
                m_rphase++;
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", obs_ready); end
        checks++;
        if (obs_front !== 1'b0) begin errors++; $display("FAIL reset_front_sel got=%b exp=0", obs_front); end
        checks++;
        if ({obs_valid, obs_busy} !== 2'b00) begin errors++; $display("FAIL reset_reader got=%b exp=00", {obs_valid, obs_busy}); end
    endtask

    task automatic test_fill();
        logic [7:0] b;
        for (int i = 0; i < L; i++) begin
            b = 8'(i);
            step(1'b0, 1'b1, {CH{b}}, 1'b0);
            checks++;
            if (obs_ready !== 1'b1) begin errors++; $display("FAIL fill_ready beat=%0d got=%b exp=1", i, obs_ready); end
        end
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (obs_ready !== 1'b0) begin errors++; $display("FAIL fill_full got=%b exp=0", obs_ready); end
    endtask

    task automatic test_swap_read();
        int n;
        int first;
        logic [7:0] b;
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obs_swap !== 1'b1) begin errors++; $display("FAIL swap_pulse got=%b exp=1", obs_swap); end
        n = 0; first = -1;
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (k == 1) begin
                checks++;
                if ({obs_front, obs_ready} !== 2'b11) begin errors++; $display("FAIL swap_state got=%b exp=11", {obs_front, obs_ready}); end
            end
            if (obs_valid) begin
                if (first < 0) first = k;
                b = 8'(n);
                checks++;
                if (obs_data !== {CH{b}}) begin errors++; $display("FAIL swap_pixel n=%0d got=%h exp=%h", n, obs_data, {CH{b}}); end
                n++;
            end
        end
        checks++;
        if (first !== 2) begin errors++; $display("FAIL read_latency got=%0d exp=2", first); end
        checks++;
        if (n !== L) begin errors++; $display("FAIL read_length got=%0d exp=%0d", n, L); end
    endtask

    task automatic test_underrun(output logic [PW-1:0] line_out [0:L-1]);
        int n;
        logic [7:0] b;
        for (int i = 0; i < L / 2; i++) begin
            line_out[i] = $urandom;
            step(1'b0, 1'b1, line_out[i], 1'b0);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if ({obs_under, obs_swap} !== 2'b10) begin errors++; $display("FAIL underrun_pulse got=%b exp=10", {obs_under, obs_swap}); end
        n = 0;
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (obs_valid) begin
                b = 8'(n);
                checks++;
                if (obs_data !== {CH{b}}) begin errors++; $display("FAIL replay_pixel n=%0d got=%h exp=%h", n, obs_data, {CH{b}}); end
                n++;
            end
        end
        checks++;
        if (n !== L) begin errors++; $display("FAIL replay_length got=%0d exp=%0d", n, L); end
        for (int i = L / 2; i < L; i++) begin
            line_out[i] = $urandom;
            step(1'b0, 1'b1, line_out[i], 1'b0);
        end
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (obs_ready !== 1'b0) begin errors++; $display("FAIL resume_full got=%b exp=0", obs_ready); end
    endtask

    task automatic test_back_to_back(input logic [PW-1:0] line_in [0:L-1]);
        int n;
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (obs_swap !== 1'b1) begin errors++; $display("FAIL b2b_swap got=%b exp=1", obs_swap); end
        n = 0;
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 1'b1, $urandom, (k == 6));
            if (k == 6) begin
                checks++;
                if (obs_serr !== 1'b1) begin errors++; $display("FAIL start_err got=%b exp=1", obs_serr); end
            end
            if (obs_valid) begin
                checks++;
                if (obs_data !== line_in[n]) begin errors++; $display("FAIL b2b_pixel n=%0d got=%h exp=%h", n, obs_data, line_in[n]); end
                n++;
            end
        end
        checks++;
        if (n !== L) begin errors++; $display("FAIL b2b_length got=%0d exp=%0d", n, L); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 7) == 0);
        end
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, '0, 1'b1);
        for (int k = 1; k < 7; k++) step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (obs_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", obs_valid); end
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if ({obs_valid, bank_a_cen, bank_b_cen, obs_front, obs_ready} !== 5'b01101) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=01101", {obs_valid, bank_a_cen, bank_b_cen, obs_front, obs_ready});
        end
    endtask

    initial begin
        logic [PW-1:0] line_b [0:L-1];
        test_reset();
        test_fill();
        test_swap_read();
        test_underrun(line_b);
        test_back_to_back(line_b);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0, 1'b0);
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
